// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory-access stage: opcodes, LSU FSM states and
// RISC-V load/store size codes.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_ALU   = 7'b0110011,
    OP_ALUI  = 7'b0010011
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: single request with valid/ack handshake, read data valid
// in the ack cycle.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load
// extraction with sign/zero extension, and the illegal/misaligned flag.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic            write,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext,
  output logic            illegal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Loads keep all four lanes enabled and drive zero store data.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = '0;
    rdata_ext  = '0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        if (write) begin
          wdata_lane = {4{wdata[7:0]}};
          be         = 4'b0001 << addr_lo;
        end else begin
          rdata_ext = {{24{rd_byte[7]}}, rd_byte};
        end
      end
      F3_H: begin
        illegal = addr_lo[0];
        if (write) begin
          wdata_lane = {2{wdata[15:0]}};
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        end else begin
          rdata_ext = {{16{rd_half[15]}}, rd_half};
        end
      end
      F3_W: begin
        illegal = (addr_lo != 2'b00);
        if (write) begin
          wdata_lane = wdata;
        end else begin
          rdata_ext = rdata;
        end
      end
      F3_BU: begin
        illegal   = write;
        rdata_ext = {24'h0, rd_byte};
      end
      F3_HU: begin
        illegal   = write | addr_lo[0];
        rdata_ext = {16'h0, rd_half};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one bus transaction per load/store, stalls the
// core until ack, fault or timeout, and returns the extended load result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      stall,
  output logic                      done,
  output logic                      fault,
  output logic [XLEN-1:0]           load_data,
  load_store_unit_if.master         mem
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       funct3_q;
  logic             write_q;

  logic [1:0]       al_addr;
  logic [2:0]       al_funct3;
  logic             al_write;
  logic [BE_W-1:0]  al_be;
  logic [XLEN-1:0]  al_wdata;
  logic [XLEN-1:0]  al_rdata;
  logic             al_illegal;

  // Live request fields decide the issue in IDLE; latched ones drive extraction in WAIT.
  assign al_addr   = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;
  assign al_funct3 = (state_q == IDLE) ? req_funct3    : funct3_q;
  assign al_write  = (state_q == IDLE) ? req_write     : write_q;

  lsu_lane_align u_align (
    .addr_lo    (al_addr),
    .funct3     (al_funct3),
    .write      (al_write),
    .wdata      (req_wdata),
    .rdata      (mem.mem_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .illegal    (al_illegal)
  );

  assign stall = req_valid && (state_q != DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_lo_q     <= '0;
      funct3_q      <= '0;
      write_q       <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      load_data     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (al_illegal) begin
              state_q   <= DONE;
              done      <= 1'b1;
              fault     <= 1'b1;
              load_data <= '0;
            end else begin
              state_q       <= WAIT;
              addr_lo_q     <= req_addr[1:0];
              funct3_q      <= req_funct3;
              write_q       <= req_write;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_write;
              mem.mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem.mem_wdata <= al_wdata;
              mem.mem_be    <= al_be;
            end
          end
        end
        WAIT: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (mem.mem_ack) begin
            state_q     <= DONE;
            done        <= 1'b1;
            load_data   <= write_q ? '0 : al_rdata;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            state_q     <= DONE;
            done        <= 1'b1;
            fault       <= 1'b1;
            load_data   <= '0;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit plus reset-in-WAIT sequence.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit_if mem_if();

  load_store_unit #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    int          e_req_cycles;
    int          e_done_cyc;
    logic        e_fault;
    logic [31:0] e_load;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mk(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, int ack, logic [31:0] ea, logic [31:0] ewd,
                              logic [3:0] ebe, int ereq, int edone, logic ef, logic [31:0] eld);
    vec_t v;
    v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_cyc = ack;
    v.e_addr = ea; v.e_wdata = ewd; v.e_be = ebe; v.e_req_cycles = ereq;
    v.e_done_cyc = edone; v.e_fault = ef; v.e_load = eld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int req_cycles = 0;
    int done_cyc   = -1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.write;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_if.mem_rdata = v.rdata;
    mem_if.mem_ack   = 1'b0;
    #1;
    chk($sformatf("v%0d_stall_c0", idx), 32'(stall), 32'd1);
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cyc = cyc;
      end else begin
        chk($sformatf("v%0d_stall_c%0d", idx, cyc), 32'(stall), 32'd1);
        if (mem_if.mem_req) begin
          req_cycles++;
          chk($sformatf("v%0d_addr_c%0d", idx, cyc), mem_if.mem_addr, v.e_addr);
          chk($sformatf("v%0d_wdata_c%0d", idx, cyc), mem_if.mem_wdata, v.e_wdata);
          chk($sformatf("v%0d_be_c%0d", idx, cyc), 32'(mem_if.mem_be), 32'(v.e_be));
          chk($sformatf("v%0d_we_c%0d", idx, cyc), 32'(mem_if.mem_we), 32'(v.write));
        end
        mem_if.mem_ack = (cyc == v.ack_cyc);
      end
    end
    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d_done_timeout: no done within 40 cycles", idx);
    end else begin
      chk($sformatf("v%0d_done_cyc", idx), 32'(done_cyc), 32'(v.e_done_cyc));
      chk($sformatf("v%0d_fault", idx), 32'(fault), 32'(v.e_fault));
      chk($sformatf("v%0d_load", idx), load_data, v.e_load);
      chk($sformatf("v%0d_stall_done", idx), 32'(stall), 32'd0);
      chk($sformatf("v%0d_req_done", idx), 32'(mem_if.mem_req), 32'd0);
    end
    chk($sformatf("v%0d_req_cycles", idx), 32'(req_cycles), 32'(v.e_req_cycles));
    mem_if.mem_ack = 1'b0;
    req_valid      = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
  endtask

  initial begin
    // write f3 addr wdata rdata ack | addr wdata be reqcyc donecyc fault load
    vecs[0]  = mk(1, F3_W,   32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          1,
                  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1, 2, 0, 32'h0);
    vecs[1]  = mk(0, F3_B,   32'h0000_0103, 32'h0,          32'h8012_3456, 1,
                  32'h0000_0100, 32'h0,          4'b1111, 1, 2, 0, 32'hFFFF_FF80);
    vecs[2]  = mk(0, F3_BU,  32'h0000_0103, 32'h0,          32'h8012_3456, 1,
                  32'h0000_0100, 32'h0,          4'b1111, 1, 2, 0, 32'h0000_0080);
    vecs[3]  = mk(0, F3_HU,  32'h0000_0102, 32'h0,          32'h8012_3456, 1,
                  32'h0000_0100, 32'h0,          4'b1111, 1, 2, 0, 32'h0000_8012);
    vecs[4]  = mk(1, F3_H,   32'h0000_0102, 32'h0000_BEEF, 32'h0,          3,
                  32'h0000_0100, 32'hBEEF_BEEF, 4'b1100, 3, 4, 0, 32'h0);
    vecs[5]  = mk(0, F3_W,   32'h0000_0101, 32'h0,          32'h1111_1111, 1,
                  32'h0,         32'h0,          4'b0000, 0, 1, 1, 32'h0);
    vecs[6]  = mk(0, 3'b011, 32'h0000_0100, 32'h0,          32'h1111_1111, 1,
                  32'h0,         32'h0,          4'b0000, 0, 1, 1, 32'h0);
    vecs[7]  = mk(1, F3_B,   32'h0000_0101, 32'h0000_00A5, 32'h0,          2,
                  32'h0000_0100, 32'hA5A5_A5A5, 4'b0010, 2, 3, 0, 32'h0);
    vecs[8]  = mk(0, F3_H,   32'h0000_0100, 32'h0,          32'h1234_F00D, 1,
                  32'h0000_0100, 32'h0,          4'b1111, 1, 2, 0, 32'hFFFF_F00D);
    vecs[9]  = mk(0, F3_W,   32'h0000_0104, 32'h0,          32'hCAFE_F00D, 2,
                  32'h0000_0104, 32'h0,          4'b1111, 2, 3, 0, 32'hCAFE_F00D);
    vecs[10] = mk(0, F3_W,   32'h0000_0200, 32'h0,          32'h5555_AAAA, 0,
                  32'h0000_0200, 32'h0,          4'b1111, 15, 16, 1, 32'h0);
    vecs[11] = mk(0, F3_W,   32'h0000_0200, 32'h0,          32'h5555_AAAA, 15,
                  32'h0000_0200, 32'h0,          4'b1111, 15, 16, 0, 32'h5555_AAAA);
    vecs[12] = mk(1, F3_BU,  32'h0000_0100, 32'h0000_0011, 32'h0,          1,
                  32'h0,         32'h0,          4'b0000, 0, 1, 1, 32'h0);

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_be", 32'(mem_if.mem_be), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_load", load_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset while in WAIT, then a late ack must be ignored.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h0000_0300;
    mem_if.mem_rdata = 32'h0BAD_0BAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rw_req_before", 32'(mem_if.mem_req), 32'd1);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rw_req_after", 32'(mem_if.mem_req), 32'd0);
    chk("rw_state", 32'(dut.state_q), 32'(IDLE));
    chk("rw_done", 32'(done), 32'd0);
    chk("rw_fault", 32'(fault), 32'd0);
    @(negedge clk);
    reset_n        = 1'b1;
    mem_if.mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rw_late_done%0d", c), 32'(done), 32'd0);
      chk($sformatf("rw_late_fault%0d", c), 32'(fault), 32'd0);
      chk($sformatf("rw_late_req%0d", c), 32'(mem_if.mem_req), 32'd0);
      chk($sformatf("rw_late_state%0d", c), 32'(dut.state_q), 32'(IDLE));
    end
    mem_if.mem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
